ram_dma_copy: RTL and testbench

- Initiator for the single-port synchronous word RAM. Copies a block of 32-bit words from a source address range to a destination range in the same RAM.
- Drives the RAM port: address, enable, write_byte_enable, data_write. Consumes data_read, which is valid the cycle after a read-enable cycle.
- Sits beside the core as a simple memory-to-memory mover, started by a one-cycle start pulse.

---
 rtl/ram_dma_pkg.sv | 18 +
 rtl/ram_dma_copy.sv | 132 +++++++++++++
 tb/tb_ram_dma_copy.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared types and constants for the RAM block mover
// Contents: FSM state enum, RAM byte-enable encodings, transfer mode encodings.
package ram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] WBE_NONE = 4'b0000;
  localparam logic [3:0] WBE_ALL  = 4'b1111;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_copy.sv
// rtl/ram_dma_copy.sv - word-granular memory-to-memory copier on a single-port RAM
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      one-cycle request, honoured only while idle
//   src_addr, dst_addr, length transfer descriptor, latched on accepted start
//   mode, fill_value           (RAM_DMA_FILL_EN only) copy/fill select and fill word
//   busy, done                 transfer in progress / one-cycle completion pulse
//   mem_*                      RAM initiator port; mem_data_read has one-cycle latency
// Build option: define RAM_DMA_FILL_EN to add the fill mode and its two ports.
module ram_dma_copy
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef RAM_DMA_FILL_EN
  input  logic                  mode,
  input  logic [31:0]           fill_value,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  output logic [3:0]            mem_write_byte_enable,
  output logic [31:0]           mem_data_write,
  input  logic [31:0]           mem_data_read
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic                  mode_q;
  logic [31:0]           fill_q;

  // Without the fill option the mode is pinned to copy so the datapath below
  // is the same in both builds; the fill register folds away.
  logic                  mode_in;
  logic [31:0]           fill_in;
`ifdef RAM_DMA_FILL_EN
  assign mode_in = mode;
  assign fill_in = fill_value;
`else
  assign mode_in = MODE_COPY;
  assign fill_in = '0;
`endif

  logic accept;
  logic last_word;
  logic fill_active;

  assign accept      = (state_q == IDLE) && start && (length != '0);
  assign last_word   = (count_q == LEN_WIDTH'(1));
  assign fill_active = (mode_q == MODE_FILL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q   <= src_addr;
        dst_q   <= dst_addr;
        count_q <= length;
        mode_q  <= mode_in;
        fill_q  <= fill_in;
      end
      // Pointers advance once per written word; wrap at the top of memory.
      if (state_q == WR) begin
        src_q   <= src_q + ADDR_WIDTH'(1);
        dst_q   <= dst_q + ADDR_WIDTH'(1);
        count_q <= count_q - LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0)            state_d = DONE;
          else if (mode_in == MODE_FILL) state_d = WR;
          else                         state_d = RD;
        end
      end
      RD:   state_d = WR;
      WR: begin
        if (last_word)        state_d = DONE;
        else if (fill_active) state_d = WR;
        else                  state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port decode. In WR the read word from the preceding RD cycle is
  // forwarded straight to the write port without a holding register.
  always_comb begin
    busy                  = (state_q != IDLE);
    done                  = (state_q == DONE);
    mem_enable            = 1'b0;
    mem_write_byte_enable = WBE_NONE;
    mem_address           = '0;
    mem_data_write        = '0;
    case (state_q)
      RD: begin
        mem_enable  = 1'b1;
        mem_address = src_q;
      end
      WR: begin
        mem_enable            = 1'b1;
        mem_write_byte_enable = WBE_ALL;
        mem_address           = dst_q;
        mem_data_write        = fill_active ? fill_q : mem_data_read;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_dma_copy.sv
// tb/tb_ram_dma_copy.sv - directed self-checking bench for ram_dma_copy with a behavioural RAM
module tb_ram_dma_copy;

  localparam int AW    = 15;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] length;
`ifdef RAM_DMA_FILL_EN
  logic          mode;
  logic [31:0]   fill_value;
`endif
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_enable;
  logic [3:0]    mem_write_byte_enable;
  logic [31:0]   mem_data_write;
  logic [31:0]   mem_data_read;

  always #5 clk = ~clk;

  ram_dma_copy #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .src_addr              (src_addr),
    .dst_addr              (dst_addr),
    .length                (length),
`ifdef RAM_DMA_FILL_EN
    .mode                  (mode),
    .fill_value            (fill_value),
`endif
    .busy                  (busy),
    .done                  (done),
    .mem_address           (mem_address),
    .mem_enable            (mem_enable),
    .mem_write_byte_enable (mem_write_byte_enable),
    .mem_data_write        (mem_data_write),
    .mem_data_read         (mem_data_read)
  );

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 | (a & 32'h7FFF);
  endfunction

  // Behavioural RAM target plus a tb-side preload port.
  logic [31:0]   ram [0:DEPTH-1];
  bit            ram_inited = 1'b0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
      ram_inited <= 1'b1;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_write_byte_enable[b]) ram[mem_address][8*b +: 8] <= mem_data_write[8*b +: 8];
      if (mem_write_byte_enable == 4'b0000) mem_data_read <= ram[mem_address];
    end
  end

  // Expected bus activity, one record per cycle; empty queue means idle.
  typedef struct packed {
    logic          busy;
    logic          done;
    logic          en;
    logic [3:0]    wbe;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  localparam exp_t IDLE_E = '{busy: 1'b0, done: 1'b0, en: 1'b0, wbe: 4'h0, addr: '0, data: '0};

  exp_t        expq[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          ref_inited = 1'b0;
  int          ntests = 0;
  int          nfail  = 0;
  int          cyc    = 0;
  bit          chk_en = 1'b0;
  int          done_cnt = 0;
  int          done_at  = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!ref_inited) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
      ref_inited = 1'b1;
    end
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
    if (chk_en) begin
      e = (expq.size() != 0) ? expq.pop_front() : IDLE_E;
      check("status{busy,done,en,wbe}", {busy, done, mem_enable, mem_write_byte_enable},
            {e.busy, e.done, e.en, e.wbe});
      if (e.en) check("mem_address", mem_address, e.addr);
      if (e.wbe == 4'hF) begin
        check("mem_data_write", mem_data_write, e.data);
        ref_mem[e.addr] = e.data;
      end
    end
  end

  // Builds the cycle-by-cycle expectation for one request from the transfer
  // rules: forward word-by-word copy (source sees earlier writes of the same
  // transfer), or a fill of consecutive destination words.
  task automatic push_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int n, input logic [31:0] fv);
    logic [31:0]   ovl [int];
    logic [AW-1:0] sa, da;
    logic [31:0]   v;
    exp_t          e;
    expq.push_back(IDLE_E);
    for (int i = 0; i < n; i++) begin
      sa = s + AW'(i);
      da = d + AW'(i);
      if (!m) begin
        e = '{busy: 1'b1, done: 1'b0, en: 1'b1, wbe: 4'h0, addr: sa, data: '0};
        expq.push_back(e);
        v = ovl.exists(int'(sa)) ? ovl[int'(sa)] : ref_mem[sa];
      end else begin
        v = fv;
      end
      ovl[int'(da)] = v;
      e = '{busy: 1'b1, done: 1'b0, en: 1'b1, wbe: 4'hF, addr: da, data: v};
      expq.push_back(e);
    end
    e = '{busy: 1'b1, done: 1'b1, en: 1'b0, wbe: 4'h0, addr: '0, data: '0};
    expq.push_back(e);
  endtask

  task automatic mem_compare(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (bad != 0) $display("  first differing word at %h: ram %h model %h", first, ram[first], ref_mem[first]);
    check(name, bad, 0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_xfer(input string name, input logic m, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input int n, input logic [31:0] fv,
                          input int exp_lat);
    int c0, d0;
    @(posedge clk); #1;
    push_xfer(m, s, d, n, fv);
    start = 1'b1; src_addr = s; dst_addr = d; length = LW'(n);
`ifdef RAM_DMA_FILL_EN
    mode = m; fill_value = fv;
`endif
    c0 = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2 * n + 20 && done_cnt == d0; k++) @(posedge clk);
    if (done_cnt == d0) begin
      ntests++; nfail++;
      $display("FAIL %s_timeout: no done pulse within %0d cycles", name, 2 * n + 20);
    end else begin
      check({name, "_latency"}, done_at - c0, exp_lat);
    end
    repeat (2) @(posedge clk); #1;
    check({name, "_busy_after"}, busy, 1'b0);
    expq.delete();
    mem_compare({name, "_memory"});
  endtask

  localparam logic [31:0] A0 = 32'hA000_0001, A1 = 32'hA000_0002, A2 = 32'hA000_0003, A3 = 32'hA000_0004;
  localparam logic [31:0] B0 = 32'hB000_0010, B1 = 32'hB000_0020, B2 = 32'hB000_0030, B3 = 32'hB000_0040;
  localparam logic [31:0] XV = 32'h5EED_1234;

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
`ifdef RAM_DMA_FILL_EN
    mode = 1'b0; fill_value = '0;
`endif
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_enable", mem_enable, 1'b0);
    check("rst_wbe", mem_write_byte_enable, 4'h0);
    check("rst_address", mem_address, '0);
    check("rst_data_write", mem_data_write, '0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Basic 4-word copy.
    preload(15'h10, A0); preload(15'h11, A1); preload(15'h12, A2); preload(15'h13, A3);
    run_xfer("copy4", 1'b0, 15'h10, 15'h100, 4, '0, 9);
    check("copy4_w0", ram[15'h100], A0);
    check("copy4_w1", ram[15'h101], A1);
    check("copy4_w2", ram[15'h102], A2);
    check("copy4_w3", ram[15'h103], A3);

    // Zero length: straight to done, no RAM access.
    run_xfer("len0", 1'b0, 15'h50, 15'h60, 0, '0, 1);

    // Source wraps past the top address.
    preload(15'h7FFE, B0); preload(15'h7FFF, B1); preload(15'h0000, B2); preload(15'h0001, B3);
    run_xfer("wrap", 1'b0, 15'h7FFE, 15'h20, 4, '0, 9);
    check("wrap_w0", ram[15'h20], B0);
    check("wrap_w1", ram[15'h21], B1);
    check("wrap_w2", ram[15'h22], B2);
    check("wrap_w3", ram[15'h23], B3);

    // Forward overlap replicates the first word.
    preload(15'h40, XV);
    run_xfer("overlap", 1'b0, 15'h40, 15'h41, 3, '0, 7);
    check("overlap_w1", ram[15'h41], XV);
    check("overlap_w2", ram[15'h42], XV);
    check("overlap_w3", ram[15'h43], XV);

    // In-place copy.
    run_xfer("inplace", 1'b0, 15'h10, 15'h10, 2, '0, 5);
    check("inplace_w0", ram[15'h10], A0);

    // Second start while busy, then reset during the second WR cycle.
    @(posedge clk); #1;
    push_xfer(1'b0, 15'h300, 15'h310, 4, '0);
    start = 1'b1; src_addr = 15'h300; dst_addr = 15'h310; length = LW'(4);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 15'h500; dst_addr = 15'h600; length = LW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expq.delete();
    check("rstmid_enable", mem_enable, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    repeat (12) @(posedge clk); #1;
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_w0", ram[15'h310], init_val(15'h300));
    check("rstmid_w1", ram[15'h311], init_val(15'h301));
    check("rstmid_w2_untouched", ram[15'h312], init_val(15'h312));
    check("rstmid_ignored_dst", ram[15'h600], init_val(15'h600));
    mem_compare("rstmid_memory");

`ifdef RAM_DMA_FILL_EN
    run_xfer("fill5", 1'b1, 15'h0, 15'h200, 5, 32'hDEADBEEF, 6);
    for (int i = 0; i < 5; i++) check("fill5_word", ram[15'h200 + i], 32'hDEADBEEF);
    check("fill5_next_untouched", ram[15'h205], init_val(15'h205));
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
